// File: rtl/ita_package.sv
// ita_package: shared divider-bank sizing, lane state encoding and dividend constant.
package ita_package;
  localparam int unsigned NumDiv              = 4;
  localparam int unsigned DividerWidth        = 16;
  localparam int unsigned SoftmaxAccDataWidth = 19;
  localparam logic [DividerWidth-1:0] DivDividend = DividerWidth'((2 ** 16) - 1);
  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;
endpackage

// File: rtl/ita_serial_div.sv
// ita_serial_div: one restoring-division lane computing Dividend / divisor.
// Define ITA_DIV_RADIX4_EN to retire two quotient bits per BUSY cycle.
module ita_serial_div
  import ita_package::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned AccW     = 19,
  parameter logic [W-1:0] Dividend = '1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AccW-1:0] inp_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [W-1:0]    oup_o
);
`ifdef ITA_DIV_RADIX4_EN
  localparam int unsigned Iter = W / 2;
  if (W % 2 != 0) begin : g_odd_width
    $error("ita_serial_div: radix-4 mode needs an even quotient width");
  end
`else
  localparam int unsigned Iter = W;
`endif
  localparam int unsigned CntW = $clog2(Iter + 1);
  localparam logic [CntW-1:0] Last = CntW'(Iter - 1);

  div_state_e     state;
  logic [AccW-1:0] divisor;
  logic [AccW:0]   rem;
  logic [W-1:0]    sh;
  logic [CntW-1:0] cnt;
  logic [AccW+W:0] s1, nxt;

  // {remainder, shift register}: dividend bits leave at the top, quotient bits enter at the bottom
  function automatic logic [AccW+W:0] step(logic [AccW:0] r, logic [W-1:0] s, logic [AccW-1:0] d);
    logic [AccW:0] t;
    logic          ge;
    t  = (r << 1) | {{AccW{1'b0}}, s[W-1]};
    ge = t >= {1'b0, d};
    return {ge ? t - {1'b0, d} : t, s[W-2:0], ge};
  endfunction

  assign s1 = step(rem, sh, divisor);
`ifdef ITA_DIV_RADIX4_EN
  assign nxt = step(s1[AccW+W:W], s1[W-1:0], divisor);
`else
  assign nxt = s1;
`endif

  assign ready_o = state == DivIdle;
  assign valid_o = state == DivDone;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= DivIdle;
      divisor <= '0;
      rem     <= '0;
      sh      <= '0;
      cnt     <= '0;
      oup_o   <= '0;
    end else begin
      case (state)
        DivIdle: if (valid_i) begin
          divisor <= inp_i;
          rem     <= '0;
          sh      <= Dividend;
          cnt     <= '0;
          if (inp_i == '0) begin
            oup_o <= '1;
            state <= DivDone;
          end else begin
            state <= DivBusy;
          end
        end
        DivBusy: begin
          rem <= nxt[AccW+W:W];
          sh  <= nxt[W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == Last) begin
            oup_o <= nxt[W-1:0];
            state <= DivDone;
          end
        end
        DivDone: if (ready_i) state <= DivIdle;
        default: state <= DivIdle;
      endcase
    end
  end
endmodule

// File: rtl/ita_divider_bank.sv
// ita_divider_bank: NumDiv independent serial divider lanes sharing one divisor bus.
// Radix-4 lanes are selected with ITA_DIV_RADIX4_EN.
module ita_divider_bank #(
  parameter int unsigned NumDiv              = ita_package::NumDiv,
  parameter int unsigned SoftmaxAccDataWidth = ita_package::SoftmaxAccDataWidth,
  parameter int unsigned DividerWidth        = ita_package::DividerWidth,
  parameter logic [DividerWidth-1:0] Dividend = ita_package::DivDividend
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [SoftmaxAccDataWidth-1:0]         div_inp_i,
  input  logic [NumDiv-1:0]                      div_valid_i,
  output logic [NumDiv-1:0]                      div_ready_o,
  output logic [NumDiv-1:0]                      div_valid_o,
  input  logic [NumDiv-1:0]                      div_ready_i,
  output logic [NumDiv-1:0][DividerWidth-1:0]    div_oup_o
);
  for (genvar i = 0; i < NumDiv; i++) begin : g_lane
    ita_serial_div #(
      .W       (DividerWidth),
      .AccW    (SoftmaxAccDataWidth),
      .Dividend(Dividend)
    ) u_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inp_i  (div_inp_i),
      .valid_i(div_valid_i[i]),
      .ready_o(div_ready_o[i]),
      .valid_o(div_valid_o[i]),
      .ready_i(div_ready_i[i]),
      .oup_o  (div_oup_o[i])
    );
  end
endmodule

// File: tb/tb_ita_divider_bank.sv
// tb_ita_divider_bank: directed and randomized checks of the divider bank against an arithmetic model.
module tb_ita_divider_bank;
`ifdef ITA_DIV_RADIX4_EN
  localparam int BusyLat = 9;
`else
  localparam int BusyLat = 17;
`endif
  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [18:0]       div_inp_i = '0;
  logic [3:0]        div_valid_i = '0;
  logic [3:0]        div_ready_o;
  logic [3:0]        div_valid_o;
  logic [3:0]        div_ready_i = '0;
  logic [3:0][15:0]  div_oup_o;
  int checks = 0;
  int errors = 0;

  ita_divider_bank dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .div_inp_i  (div_inp_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .div_valid_o(div_valid_o),
    .div_ready_i(div_ready_i),
    .div_oup_o  (div_oup_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int ref_q(int d);
    return d == 0 ? 65535 : 65535 / d;
  endfunction

  function automatic int ref_lat(int d);
    return d == 0 ? 1 : BusyLat;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(int lane, int d);
    div_inp_i = 19'(d);
    div_valid_i = 4'(1 << lane);
    tick();
    div_valid_i = '0;
    chk("accept_ready_low", 32'(div_ready_o[lane]), 0);
  endtask

  // n counts clock edges since (and including) the accepting edge
  task automatic wait_valid(int lane, int d, int n0);
    int n = n0;
    while (!div_valid_o[lane] && n < 60) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(ref_lat(d)));
    chk("quotient", 32'(div_oup_o[lane]), 32'(ref_q(d)));
  endtask

  task automatic handoff(int lane);
    div_ready_i[lane] = 1'b1;
    tick();
    div_ready_i = '0;
    chk("handoff_valid_low", 32'(div_valid_o[lane]), 0);
    chk("handoff_ready_high", 32'(div_ready_o[lane]), 1);
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(div_ready_o), 32'hF);
    chk("rst_valid", 32'(div_valid_o), 0);
    chk("rst_oup", 32'(div_oup_o == '0), 1);
    #10 rst_ni = 1'b1;
    tick();
    // single request and boundary divisors
    do_req(0, 255); wait_valid(0, 255, 1); handoff(0);
    do_req(1, 1); wait_valid(1, 1, 1); handoff(1);
    do_req(2, 65535); wait_valid(2, 65535, 1); handoff(2);
    do_req(3, 70000); wait_valid(3, 70000, 1); handoff(3);
    do_req(0, 65536); wait_valid(0, 65536, 1); handoff(0);
    do_req(1, 0); wait_valid(1, 0, 1); handoff(1);
    do_req(2, 524287); wait_valid(2, 524287, 1); handoff(2);
    // round robin, results in lane order on consecutive cycles
    div_inp_i = 19'd3; div_valid_i = 4'b0001; tick();
    div_inp_i = 19'd5; div_valid_i = 4'b0010; tick();
    div_inp_i = 19'd7; div_valid_i = 4'b0100; tick();
    div_inp_i = 19'd9; div_valid_i = 4'b1000; tick();
    div_valid_i = '0;
    for (int i = 0; i < BusyLat - 4; i++) tick();
    chk("rr_v0", 32'(div_valid_o), 32'b0001);
    tick(); chk("rr_v1", 32'(div_valid_o), 32'b0011);
    tick(); chk("rr_v2", 32'(div_valid_o), 32'b0111);
    tick(); chk("rr_v3", 32'(div_valid_o), 32'b1111);
    chk("rr_q0", 32'(div_oup_o[0]), 32'(ref_q(3)));
    chk("rr_q1", 32'(div_oup_o[1]), 32'(ref_q(5)));
    chk("rr_q2", 32'(div_oup_o[2]), 32'(ref_q(7)));
    chk("rr_q3", 32'(div_oup_o[3]), 32'(ref_q(9)));
    div_ready_i = 4'b1011; tick(); div_ready_i = '0;
    chk("rr_partial_handoff", 32'(div_valid_o), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(div_valid_o[2]), 1);
      chk("stall_ready", 32'(div_ready_o[2]), 0);
      chk("stall_data", 32'(div_oup_o[2]), 32'(ref_q(7)));
    end
    handoff(2);
    // request on a busy lane is ignored
    do_req(1, 255);
    tick(); tick(); tick();
    div_inp_i = 19'd3; div_valid_i = 4'b0010; tick(); div_valid_i = '0;
    chk("busy_ignore_ready", 32'(div_ready_o[1]), 0);
    wait_valid(1, 255, 5);
    // handoff on lane 1 and accept on lane 2 in the same cycle
    div_ready_i = 4'b0010; div_inp_i = 19'd7; div_valid_i = 4'b0100; tick();
    div_ready_i = '0; div_valid_i = '0;
    chk("overlap_handoff", 32'(div_valid_o[1]), 0);
    chk("overlap_accept", 32'(div_ready_o[2]), 0);
    wait_valid(2, 7, 1); handoff(2);
    // asynchronous reset mid-BUSY
    do_req(0, 255);
    do_req(3, 1000);
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", 32'(div_ready_o), 32'hF);
    chk("arst_valid", 32'(div_valid_o), 0);
    chk("arst_oup", 32'(div_oup_o == '0), 1);
    #2 rst_ni = 1'b1;
    tick();
    do_req(0, 255); wait_valid(0, 255, 1); handoff(0);
    // randomized divisors on random lanes
    for (int i = 0; i < 24; i++) begin
      int lane = int'($urandom_range(0, 3));
      int sel = int'($urandom_range(0, 3));
      int d = sel == 0 ? int'($urandom_range(0, 300)) :
              sel == 1 ? int'($urandom_range(60000, 70000)) :
              int'($urandom_range(0, 524287));
      do_req(lane, d); wait_valid(lane, d, 1); handoff(lane);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
